// File: rtl/mips_multicycle_controller.sv
// Moore FSM sequencing the shared-memory multi-cycle MIPS datapath through fetch/decode/execute/memory/writeback.
// Memory states stall on mem_ready; retired counts completed instructions; undefined encodings pulse illegal_op.
module mips_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             ALUZeroFlag,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic [1:0]       RegDst,
  output logic [1:0]       DataWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       operation,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, RT_EX, RT_WB,
    IMM_EX, IMM_WB, BEQ, JUMP, JAL, JR
  } state_t;

  state_t state, nextState;
  logic   isRt, rtAlu, isJr, isLw, isSw, isAddi, isSlti, isBeq, isJ, isJal, legal, retire;

  // Branch resolution happens in the datapath via PCWriteCond, so the flag is not needed here.
  logic unusedZeroFlag;
  assign unusedZeroFlag = ALUZeroFlag;

  assign isRt   = (opcode == 6'b000000);
  assign rtAlu  = isRt && (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  assign isJr   = isRt && (funct == 6'b001000);
  assign isLw   = (opcode == 6'b100011);
  assign isSw   = (opcode == 6'b101011);
  assign isAddi = (opcode == 6'b001000);
  assign isSlti = (opcode == 6'b001010);
  assign isBeq  = (opcode == 6'b000100);
  assign isJ    = (opcode == 6'b000010);
  assign isJal  = (opcode == 6'b000011);
  assign legal  = isJr || rtAlu || isLw || isSw || isAddi || isSlti || isBeq || isJ || isJal;

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:   nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (isJr)                nextState = JR;
        else if (rtAlu)          nextState = RT_EX;
        else if (isLw || isSw)   nextState = MEMADDR;
        else if (isAddi || isSlti) nextState = IMM_EX;
        else if (isBeq)          nextState = BEQ;
        else if (isJ)            nextState = JUMP;
        else if (isJal)          nextState = JAL;
        else                     nextState = FETCH;
      end
      MEMADDR: nextState = isLw ? MEMRD : MEMWR;
      MEMRD:   nextState = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nextState = mem_ready ? FETCH : MEMWR;
      RT_EX:   nextState = RT_WB;
      IMM_EX:  nextState = IMM_WB;
      default: nextState = FETCH;
    endcase
  end

  assign retire = (state inside {MEMWB, RT_WB, IMM_WB, BEQ, JUMP, JAL, JR}) ||
                  ((state == MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= nextState;
      if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Outputs decode the current state; holding rst low forces every control line inactive at once.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; MemtoReg = 1'b0; RegDst = 2'b00; DataWrite = 2'b00; RegWrite = 1'b0;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; operation = 3'b000; PCSource = 2'b00; illegal_op = 1'b0;
    if (rst) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01; operation = 3'b010;
          IRWrite = mem_ready; PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB = 2'b11; operation = 3'b010; illegal_op = !legal;
        end
        MEMADDR: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10; operation = 3'b010;
        end
        MEMRD:  begin IorD = 1'b1; MemRead = 1'b1; end
        MEMWB:  begin MemtoReg = 1'b1; RegWrite = 1'b1; end
        MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; end
        RT_EX: begin
          ALUSrcA = 1'b1;
          case (funct)
            6'b100010: operation = 3'b110;
            6'b100100: operation = 3'b000;
            6'b100101: operation = 3'b001;
            6'b101010: operation = 3'b111;
            default:   operation = 3'b010;
          endcase
        end
        RT_WB:  begin RegDst = 2'b01; RegWrite = 1'b1; end
        IMM_EX: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10; operation = isSlti ? 3'b111 : 3'b010;
        end
        IMM_WB: RegWrite = 1'b1;
        BEQ: begin
          ALUSrcA = 1'b1; operation = 3'b110; PCWriteCond = 1'b1; PCSource = 2'b01;
        end
        JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; end
        JAL: begin
          PCWrite = 1'b1; PCSource = 2'b10; RegDst = 2'b10; DataWrite = 2'b10; RegWrite = 1'b1;
        end
        JR:     begin PCWrite = 1'b1; PCSource = 2'b11; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multi-cycle MIPS controller: instruction table, hand-written corner sequences,
// and random instruction streams scored against a per-instruction control-step model.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] RegDst, DataWrite;
    logic RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] operation;
    logic [1:0] PCSource;
    logic illegal_op;
  } outv_t;

  typedef struct { logic mr; logic dc; outv_t exp; } step_t;
  typedef struct { logic [5:0] op; logic [5:0] fn; int cyc; int dRet; } vec_t;
  typedef enum int { K_R, K_JR, K_LW, K_SW, K_ADDI, K_SLTI, K_BEQ, K_J, K_JAL, K_ILL } kind_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic ALUZeroFlag = 1'b0, mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] RegDst, DataWrite, ALUSrcB, PCSource;
  logic [2:0] operation;
  logic [3:0] retired;
  outv_t dutOut;

  int compared = 0, mismatched = 0, retModel = 0;
  step_t q[$];

  always #5 clk = ~clk;

  mips_multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ALUZeroFlag(ALUZeroFlag),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .DataWrite(DataWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .operation(operation), .PCSource(PCSource), .illegal_op(illegal_op),
    .retired(retired)
  );

  assign dutOut = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   DataWrite, RegWrite, ALUSrcA, ALUSrcB, operation, PCSource, illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic kind_t kindOf(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
            fn == 6'b100101 || fn == 6'b101010) return K_R;
        return K_ILL;
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b001000: return K_ADDI;
      6'b001010: return K_SLTI;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] aluOpOf(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010; // add
      6'b100010: return 3'b110; // sub
      6'b100100: return 3'b000; // and
      6'b100101: return 3'b001; // or
      default:   return 3'b111; // slt
    endcase
  endfunction

  function automatic outv_t fetchOut(input logic done);
    outv_t o = '0;
    o.MemRead = 1'b1; o.ALUSrcB = 2'b01; o.operation = 3'b010;
    o.IRWrite = done; o.PCWrite = done;
    return o;
  endfunction

  task automatic push(input logic mr, input logic dc, input outv_t o);
    step_t s;
    s.mr = mr; s.dc = dc; s.exp = o;
    q.push_back(s);
  endtask

  // Expected control steps for one instruction, given fetch and memory wait counts.
  task automatic buildInstr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                            output logic ret);
    outv_t o;
    kind_t k = kindOf(op, fn);
    q.delete();
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, fetchOut(1'b0));
    push(1'b1, 1'b0, fetchOut(1'b1));
    o = '0; o.ALUSrcB = 2'b11; o.operation = 3'b010; o.illegal_op = (k == K_ILL);
    push(1'b0, 1'b1, o);
    ret = (k != K_ILL);
    o = '0;
    case (k)
      K_R: begin
        o.ALUSrcA = 1'b1; o.operation = aluOpOf(fn); push(1'b0, 1'b1, o);
        o = '0; o.RegDst = 2'b01; o.RegWrite = 1'b1; push(1'b0, 1'b1, o);
      end
      K_LW, K_SW: begin
        o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.operation = 3'b010; push(1'b0, 1'b1, o);
        o = '0; o.IorD = 1'b1;
        if (k == K_LW) o.MemRead = 1'b1; else o.MemWrite = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, o);
        push(1'b1, 1'b0, o);
        if (k == K_LW) begin
          o = '0; o.MemtoReg = 1'b1; o.RegWrite = 1'b1; push(1'b0, 1'b1, o);
        end
      end
      K_ADDI, K_SLTI: begin
        o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10;
        o.operation = (k == K_SLTI) ? 3'b111 : 3'b010; push(1'b0, 1'b1, o);
        o = '0; o.RegWrite = 1'b1; push(1'b0, 1'b1, o);
      end
      K_BEQ: begin
        o.ALUSrcA = 1'b1; o.operation = 3'b110; o.PCWriteCond = 1'b1; o.PCSource = 2'b01;
        push(1'b0, 1'b1, o);
      end
      K_J:   begin o.PCWrite = 1'b1; o.PCSource = 2'b10; push(1'b0, 1'b1, o); end
      K_JAL: begin
        o.PCWrite = 1'b1; o.PCSource = 2'b10; o.RegDst = 2'b10; o.DataWrite = 2'b10;
        o.RegWrite = 1'b1; push(1'b0, 1'b1, o);
      end
      K_JR:  begin o.PCWrite = 1'b1; o.PCSource = 2'b11; push(1'b0, 1'b1, o); end
      default: ;
    endcase
  endtask

  // Entered and left #1 after a rising edge with the controller in FETCH.
  task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int fw, input int mw, input logic zf);
    logic ret;
    buildInstr(op, fn, fw, mw, ret);
    opcode = op; funct = fn;
    foreach (q[i]) begin
      mem_ready = q[i].dc ? 1'($urandom) : q[i].mr;
      ALUZeroFlag = zf;
      #2;
      check(name, 32'(dutOut), 32'(q[i].exp));
      @(posedge clk); #1;
    end
    if (ret) retModel = (retModel + 1) % 16;
    check({name, " retired"}, 32'(retired), 32'(retModel));
  endtask

  task automatic countInstr(input logic [5:0] op, input logic [5:0] fn, output int n);
    opcode = op; funct = fn; mem_ready = 1'b1; n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(dutOut.MemRead && !dutOut.IorD && dutOut.ALUSrcB == 2'b01) && n < 20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    int n;
    logic [5:0] legalOp[14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B,
                                6'h08, 6'h0A, 6'h04, 6'h02, 6'h03, 6'h3F};
    logic [5:0] legalFn[14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    tbl[0]  = '{6'b000000, 6'b100000, 4, 1};  // add
    tbl[1]  = '{6'b000000, 6'b100010, 4, 1};  // sub
    tbl[2]  = '{6'b000000, 6'b100100, 4, 1};  // and
    tbl[3]  = '{6'b000000, 6'b100101, 4, 1};  // or
    tbl[4]  = '{6'b000000, 6'b101010, 4, 1};  // slt
    tbl[5]  = '{6'b100011, 6'b000000, 5, 1};  // lw
    tbl[6]  = '{6'b101011, 6'b000000, 4, 1};  // sw
    tbl[7]  = '{6'b001000, 6'b000000, 4, 1};  // addi
    tbl[8]  = '{6'b001010, 6'b000000, 4, 1};  // slti
    tbl[9]  = '{6'b000100, 6'b000000, 3, 1};  // beq
    tbl[10] = '{6'b000010, 6'b000000, 3, 1};  // j
    tbl[11] = '{6'b000011, 6'b000000, 3, 1};  // jal
    tbl[12] = '{6'b000000, 6'b001000, 3, 1};  // jr
    tbl[13] = '{6'b000000, 6'b000001, 2, 0};  // undefined funct

    mem_ready = 1'b1;
    #3;
    check("reset outputs", 32'(dutOut), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      countInstr(tbl[i].op, tbl[i].fn, n);
      check($sformatf("tbl%0d cycles", i), 32'(n), 32'(tbl[i].cyc));
      retModel = (retModel + tbl[i].dRet) % 16;
      check($sformatf("tbl%0d retired", i), 32'(retired), 32'(retModel));
    end

    runInstr("add", 6'b000000, 6'b100000, 0, 0, 1'b0);
    runInstr("lw wait3", 6'b100011, 6'b000000, 0, 3, 1'b0);
    runInstr("beq z1", 6'b000100, 6'b000000, 0, 0, 1'b1);
    runInstr("beq z0", 6'b000100, 6'b000000, 0, 0, 1'b0);
    runInstr("jal", 6'b000011, 6'b000000, 0, 0, 1'b0);
    runInstr("jr", 6'b000000, 6'b001000, 0, 0, 1'b0);
    runInstr("illegal", 6'b111111, 6'b000000, 1, 0, 1'b0);
    runInstr("sw wait2", 6'b101011, 6'b000000, 2, 2, 1'b0);

    // Abort a store while it waits on memory.
    opcode = 6'b101011; funct = 6'b000000; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("memwr wait MemWrite", 32'({MemWrite, IorD}), 32'b11);
    rst = 1'b0;
    #1;
    check("async reset outputs", 32'(dutOut), 32'd0);
    check("async reset retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; retModel = 0;
    #1;
    check("post reset fetch", 32'(dutOut), 32'(fetchOut(1'b0)));
    check("post reset retired", 32'(retired), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      int pick = $urandom_range(0, 14);
      logic [5:0] op, fn;
      if (pick < 14) begin op = legalOp[pick]; fn = legalFn[pick]; end
      else begin op = 6'($urandom); fn = 6'($urandom); end
      runInstr($sformatf("rand%0d", i), op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
